stft_threshold_bank: RTL and testbench

Streaming threshold detector for STFT magnitude frames with a run-time programmable per-bin threshold RAM. Three compare modes (>=, >, per-bin hysteresis), and packing of per-bin decision bits into PACK-bit words. It sits between the STFT magnitude stage and the deep-learning feature buffer, one decision bit per frequency/time bin. Per frame it reports a hit count and a short-frame flag.

---
 rtl/stft_threshold_bank.sv | 171 +++++++++++++++++
 tb/tb_stft_threshold_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stft_threshold_bank.sv
// stft_threshold_bank: streaming per-bin threshold detector for STFT magnitude
// frames. Programmable threshold RAM, >= / > / hysteresis compare modes, and
// packing of decision bits into PACK-bit words with per-frame hit count.
module stft_threshold_bank #(
  parameter int unsigned IL   = 10,
  parameter int unsigned NBIN = 1024,
  parameter int unsigned AW   = 10,
  parameter int unsigned PACK = 8
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iCLR,
  input  logic [1:0]      iMODE,
  input  logic [IL-1:0]   iHYS,
  input  logic            iTH_WE,
  input  logic [AW-1:0]   iTH_ADDR,
  input  logic [IL-1:0]   iTH_DATA,
  input  logic            iEN,
  input  logic            iSOF,
  input  logic [IL-1:0]   iDATA,
  output logic            oEN,
  output logic [PACK-1:0] oDATA,
  output logic            oEOF,
  output logic            oSHORT,
  output logic [AW:0]     oHITS
);

  localparam int unsigned CW = (PACK > 1) ? $clog2(PACK) : 1;

  // Bin counter and stage-1 registers
  logic [AW-1:0]   r_bin_next;
  logic            r1_v;
  logic            r1_short;
  logic [AW-1:0]   r1_bin;
  logic [IL-1:0]   r1_data;
  logic [IL-1:0]   r1_hys;
  logic [1:0]      r1_mode;
  logic [IL-1:0]   r_th_rd;
  logic [IL-1:0]   r_ram [NBIN];

  // Stage-2 registers and hysteresis state
  logic            r2_v;
  logic            r2_dec;
  logic            r2_eof;
  logic            r2_short;
  logic [NBIN-1:0] r_h;

  // Packer state
  logic [PACK-1:0] r_pk_bits;
  logic [CW-1:0]   r_pk_cnt;
  logic [AW:0]     r_hits;

  logic [AW-1:0]   w_bin;
  logic            w_short;
  logic [IL-1:0]   w_th_lo;
  logic            w_dec;
  logic [PACK-1:0] w_pk_bits;
  logic [AW:0]     w_hits;

  // Current bin of the incoming sample; iSOF away from bin 0 ends a frame early
  always_comb begin
    w_bin   = iSOF ? '0 : r_bin_next;
    w_short = iSOF && (r_bin_next != '0);
  end

  // Stage 1: capture sample, advance bin counter
  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      r_bin_next <= '0;
      r1_v       <= 1'b0;
      r1_short   <= 1'b0;
      r1_bin     <= '0;
      r1_data    <= '0;
      r1_hys     <= '0;
      r1_mode    <= 2'b00;
    end else begin
      r1_v <= iEN;
      if (iEN) begin
        r_bin_next <= (w_bin == AW'(NBIN - 1)) ? '0 : w_bin + AW'(1);
        r1_short   <= w_short;
        r1_bin     <= w_bin;
        r1_data    <= iDATA;
        r1_hys     <= iHYS;
        r1_mode    <= iMODE;
      end
    end
  end

  // Threshold RAM: read-first, write port independent of reset
  always_ff @(posedge iCLK) begin
    if (iTH_WE) r_ram[iTH_ADDR] <= iTH_DATA;
    r_th_rd <= r_ram[w_bin];
  end

  // Stage 2 decision; the hysteresis low level floors at zero
  always_comb begin
    w_th_lo = (r_th_rd > r1_hys) ? r_th_rd - r1_hys : '0;
    case (r1_mode)
      2'b01:   w_dec = r1_data > r_th_rd;
      2'b10:   w_dec = r_h[r1_bin] ? (r1_data >= w_th_lo) : (r1_data >= r_th_rd);
      default: w_dec = r1_data >= r_th_rd;
    endcase
  end

  // Stage 2: register decision, update hysteresis state in mode 10 only
  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      r2_v     <= 1'b0;
      r2_dec   <= 1'b0;
      r2_eof   <= 1'b0;
      r2_short <= 1'b0;
      r_h      <= '0;
    end else begin
      r2_v <= r1_v;
      if (r1_v) begin
        r2_dec   <= w_dec;
        r2_eof   <= (r1_bin == AW'(NBIN - 1));
        r2_short <= r1_short;
        if (r1_mode == 2'b10) r_h[r1_bin] <= w_dec;
      end
    end
  end

  // Packer inputs with the current decision merged in
  always_comb begin
    w_pk_bits = r_pk_bits | (PACK'(r2_dec) << r_pk_cnt);
    w_hits    = r_hits + (AW + 1)'(r2_dec);
  end

  // Packer: flush on short frame, emit full words, track frame hit count
  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      oEN       <= 1'b0;
      oDATA     <= '0;
      oEOF      <= 1'b0;
      oSHORT    <= 1'b0;
      oHITS     <= '0;
      r_pk_bits <= '0;
      r_pk_cnt  <= '0;
      r_hits    <= '0;
    end else begin
      oEN <= 1'b0;
      if (r2_v) begin
        if (r2_short) begin
          oEN       <= 1'b1;
          oDATA     <= r_pk_bits;
          oEOF      <= 1'b1;
          oSHORT    <= 1'b1;
          oHITS     <= r_hits;
          r_pk_bits <= PACK'(r2_dec);
          r_pk_cnt  <= CW'(1);
          r_hits    <= (AW + 1)'(r2_dec);
        end else if (r_pk_cnt == CW'(PACK - 1)) begin
          oEN       <= 1'b1;
          oDATA     <= w_pk_bits;
          oEOF      <= r2_eof;
          oSHORT    <= 1'b0;
          oHITS     <= w_hits;
          r_pk_bits <= '0;
          r_pk_cnt  <= '0;
          r_hits    <= r2_eof ? '0 : w_hits;
        end else begin
          r_pk_bits <= w_pk_bits;
          r_pk_cnt  <= r_pk_cnt + CW'(1);
          r_hits    <= w_hits;
        end
      end
    end
  end

endmodule

// File: tb/tb_stft_threshold_bank.sv
// Testbench for stft_threshold_bank: directed and randomized frames checked
// against a queue-based reference model of frames, bins and packed words.
module tb_stft_threshold_bank;

  localparam int unsigned IL   = 10;
  localparam int unsigned NBIN = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned PACK = 8;

  logic            iCLK = 1'b0;
  logic            iRST, iCLR, iTH_WE, iEN, iSOF;
  logic [1:0]      iMODE;
  logic [IL-1:0]   iHYS, iTH_DATA, iDATA;
  logic [AW-1:0]   iTH_ADDR;
  logic            oEN, oEOF, oSHORT;
  logic [PACK-1:0] oDATA;
  logic [AW:0]     oHITS;

  stft_threshold_bank #(.IL(IL), .NBIN(NBIN), .AW(AW), .PACK(PACK)) dut (
    .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iMODE(iMODE), .iHYS(iHYS),
    .iTH_WE(iTH_WE), .iTH_ADDR(iTH_ADDR), .iTH_DATA(iTH_DATA),
    .iEN(iEN), .iSOF(iSOF), .iDATA(iDATA),
    .oEN(oEN), .oDATA(oDATA), .oEOF(oEOF), .oSHORT(oSHORT), .oHITS(oHITS)
  );

  always #5 iCLK = ~iCLK;

  // Stimulus variables applied by tick()
  logic          rst = 1'b0, clr = 1'b0, en = 1'b0, sof = 1'b0, we = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [IL-1:0] data = '0, hys = 10'd20, wd = '0;
  logic [AW-1:0] wa = '0;

  int n_cmp = 0;
  int n_err = 0;
  int e = 0;

  // Reference model state
  typedef struct {
    int              stamp;
    logic [PACK-1:0] data;
    logic            eof;
    logic            sh;
    logic [AW:0]     hits;
  } word_t;

  word_t q[$];
  int    m_th[NBIN];
  bit    m_h[NBIN];
  int    m_next = 0;
  bit    m_bits[$];
  int    m_hits = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s tick=%0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic emit(input int stamp, input bit eof, input bit sh);
    word_t w;
    w.stamp = stamp;
    w.data  = '0;
    for (int i = 0; i < m_bits.size(); i++) w.data[i] = m_bits[i];
    w.eof  = eof;
    w.sh   = sh;
    w.hits = (AW + 1)'(m_hits);
    q.push_back(w);
    m_bits.delete();
  endtask

  task automatic model_reset(input int stamp);
    while (q.size() > 0 && q[$].stamp >= stamp) void'(q.pop_back());
    for (int i = 0; i < NBIN; i++) m_h[i] = 1'b0;
    m_next = 0;
    m_bits.delete();
    m_hits = 0;
  endtask

  task automatic model_sample(input int stamp);
    int bin, th, lo, d;
    bit dec;
    bin = sof ? 0 : m_next;
    th  = m_th[bin];
    d   = int'(data);
    if (sof && m_next != 0) begin
      emit(stamp, 1'b1, 1'b1);
      m_hits = 0;
    end
    case (mode)
      2'b01: dec = d > th;
      2'b10: begin
        lo = th - int'(hys);
        if (lo < 0) lo = 0;
        if (m_h[bin]) dec = !(d < lo);
        else          dec = d >= th;
        m_h[bin] = dec;
      end
      default: dec = d >= th;
    endcase
    m_bits.push_back(dec);
    m_hits += int'(dec);
    if (m_bits.size() == PACK) begin
      emit(stamp, bin == NBIN - 1, 1'b0);
      if (bin == NBIN - 1) m_hits = 0;
    end
    m_next = (bin == NBIN - 1) ? 0 : bin + 1;
  endtask

  // One clock: drive, advance model, then check outputs after the edge
  task automatic tick();
    word_t w;
    iRST = rst; iCLR = clr; iEN = en; iSOF = sof; iDATA = data; iMODE = mode;
    iHYS = hys; iTH_WE = we; iTH_ADDR = wa; iTH_DATA = wd;
    if (rst || clr)  model_reset(e);
    else if (en)     model_sample(e + 2);
    if (we) m_th[wa] = int'(wd);
    @(posedge iCLK);
    #1;
    if (rst || clr) begin
      check("rst_oEN", 32'(oEN), 32'd0);
      check("rst_oDATA", 32'(oDATA), 32'd0);
      check("rst_oEOF", 32'(oEOF), 32'd0);
      check("rst_oSHORT", 32'(oSHORT), 32'd0);
      check("rst_oHITS", 32'(oHITS), 32'd0);
    end else if (q.size() > 0 && q[0].stamp == e) begin
      w = q.pop_front();
      check("oEN", 32'(oEN), 32'd1);
      check("oDATA", 32'(oDATA), 32'(w.data));
      check("oEOF", 32'(oEOF), 32'(w.eof));
      check("oSHORT", 32'(oSHORT), 32'(w.sh));
      if (w.eof) check("oHITS", 32'(oHITS), 32'(w.hits));
    end else begin
      check("oEN_idle", 32'(oEN), 32'd0);
    end
    e++;
  endtask

  task automatic put(input logic s, input logic [IL-1:0] d);
    en = 1'b1; sof = s; data = d;
    tick();
    en = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_th(input int a, input int v);
    we = 1'b1; wa = AW'(a); wd = IL'(v);
    tick();
    we = 1'b0;
  endtask

  initial begin
    iRST = 1'b1; iCLR = 1'b0; iEN = 1'b0; iSOF = 1'b0; iDATA = '0; iMODE = '0;
    iHYS = '0; iTH_WE = 1'b0; iTH_ADDR = '0; iTH_DATA = '0;

    // Reset while loading th[i]=i: writes proceed during reset
    rst = 1'b1;
    for (int i = 0; i < NBIN; i++) write_th(i, i);
    rst = 1'b0;
    idle(2);

    // Mode 00: data=8 gives 0xFF, 0x01, hits 9
    mode = 2'b00;
    for (int i = 0; i < NBIN; i++) put(i == 0, 10'd8);
    idle(4);

    // Mode 01: equality at bin 8 is a miss, hits 8
    mode = 2'b01;
    for (int i = 0; i < NBIN; i++) put(i == 0, 10'd8);
    idle(4);

    // Hysteresis on bin 3 with th=100, margin 20
    write_th(3, 100);
    mode = 2'b10;
    for (int f = 0; f < 4; f++) begin
      int v3;
      v3 = (f == 0) ? 100 : (f == 1) ? 90 : (f == 2) ? 79 : 85;
      for (int i = 0; i < NBIN; i++)
        put(i == 0, (i == 3) ? IL'(v3) : IL'($urandom_range(0, 30)));
    end
    idle(4);
    write_th(3, 3);

    // Short frame after 11 bins, then a full frame
    mode = 2'b00;
    for (int i = 0; i < 11; i++) put(i == 0, IL'($urandom_range(0, 20)));
    for (int i = 0; i < NBIN; i++) put(i == 0, IL'($urandom_range(0, 20)));
    idle(4);

    // Short frame on a word boundary: packer empty, zero word flushed
    for (int i = 0; i < 8; i++) put(i == 0, 10'd15);
    for (int i = 0; i < NBIN; i++) put(i == 0, 10'd15);
    idle(4);

    // Read/write collision on bin 5: old th=50 is compared this frame
    write_th(5, 50);
    for (int i = 0; i < NBIN; i++) begin
      if (i == 5) begin we = 1'b1; wa = 4'd5; wd = 10'd0; end
      put(i == 0, 10'd10);
      we = 1'b0;
    end
    for (int i = 0; i < NBIN; i++) put(i == 0, 10'd10);
    idle(4);
    write_th(5, 5);

    // Reset mid-frame, then 16 bins with no SOF: exactly two words
    for (int i = 0; i < 11; i++) put(i == 0, 10'd9);
    rst = 1'b1; en = 1'b1; data = 10'd9;
    tick();
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < NBIN; i++) put(1'b0, 10'd9);
    idle(4);

    // Soft clear mid-frame behaves like reset
    mode = 2'b10;
    for (int i = 0; i < 6; i++) put(i == 0, IL'($urandom_range(0, 20)));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < NBIN; i++) put(1'b0, IL'($urandom_range(0, 20)));
    idle(4);

    // Randomized traffic: new thresholds, gaps, SOFs, mode changes, writes
    for (int i = 0; i < NBIN; i++) write_th(i, int'($urandom_range(0, 1023)));
    for (int n = 0; n < 600; n++) begin
      en   = ($urandom_range(0, 3) != 0);
      sof  = en && ($urandom_range(0, 19) == 0);
      data = IL'($urandom_range(0, 1023));
      mode = 2'($urandom_range(0, 3));
      we   = ($urandom_range(0, 9) == 0);
      wa   = AW'($urandom_range(0, NBIN - 1));
      wd   = IL'($urandom_range(0, 1023));
      clr  = ($urandom_range(0, 149) == 0);
      tick();
    end
    en = 1'b0; sof = 1'b0; we = 1'b0; clr = 1'b0;
    idle(6);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
